// File: rtl/spi_fifo_reader.sv
// spi_fifo_reader
//   Fetches words from the read port of the SPI FIFO, one per
//   req_b/resp_b/ack_b transaction. Each word goes into a small circular
//   buffer. The buffer is drained as a valid/ready stream toward the SPI TX
//   shifter. Every transaction is guarded by a response timeout, and a
//   timeout sets a sticky error flag.
// Ports
//   clk_i, rst_i      clock; synchronous active-high reset
//   enable_i          allow new requests (a transaction in flight always completes)
//   fifo_empty_i      FIFO empty status
//   req_b_o           1-cycle read request pulse
//   resp_b_i/data_b_i FIFO response and data (data valid while resp is high)
//   ack_b_o           1-cycle acknowledge pulse (the FIFO pops on it)
//   tx_data_o/tx_valid_o/tx_ready_i  head-of-buffer stream
//   buf_count_o       buffered word count
//   timeout_err_o     sticky timeout flag, cleared only by rst_i
module spi_fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 2,
  parameter int BUF_ADDR   = 1,
  parameter int TO_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  output logic                  req_b_o,
  input  logic                  resp_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic                  ack_b_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [BUF_ADDR:0]     buf_count_o,
  output logic                  timeout_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_SETTLE} state_t;

  localparam logic [BUF_ADDR:0]   DEPTH_L = (BUF_ADDR+1)'(BUF_DEPTH);
  // The counter holds k-1 in the k-th WAIT cycle. The timeout therefore
  // fires in the cycle whose increment would take it to all-ones. That
  // gives 2**TO_WIDTH-1 WAIT cycles without a response.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((1 << TO_WIDTH) - 2);

  state_t                  state_q, state_d;
  logic [TO_WIDTH-1:0]     to_cnt_q;
  logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];
  logic [BUF_ADDR-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [BUF_ADDR:0]       count_d;
  logic                    push, pop, timeout_hit;

  always_comb begin
    push        = (state_q == S_WAIT) && resp_b_i;
    timeout_hit = (state_q == S_WAIT) && !resp_b_i && (to_cnt_q == TO_LAST);
    pop         = tx_valid_o && tx_ready_i;   // tx_valid_o low => pop ignored
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = buf_count_o;
    case ({push, pop})
      2'b10:   count_d = buf_count_o + 1'b1;
      2'b01:   count_d = buf_count_o - 1'b1;
      default: count_d = buf_count_o;
    endcase
  end

  // Space is checked only here. Between this check and the capture, the
  // buffer can only drain, so a capture never finds it full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable_i && !fifo_empty_i && (buf_count_o < DEPTH_L)) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   if (resp_b_i) state_d = S_ACK;
                else if (timeout_hit) state_d = S_IDLE;
      S_ACK:    state_d = S_SETTLE;
      S_SETTLE: if (!resp_b_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      req_b_o       <= 1'b0;
      ack_b_o       <= 1'b0;
      to_cnt_q      <= '0;
      timeout_err_o <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      buf_count_o   <= '0;
      tx_valid_o    <= 1'b0;
      tx_data_o     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      // Pulses are registered from the next state, so they line up with REQ/ACK.
      req_b_o  <= (state_d == S_REQ);
      ack_b_o  <= (state_d == S_ACK);
      to_cnt_q <= (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
      if (timeout_hit) timeout_err_o <= 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= data_b_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q    <= rd_ptr_d;
      buf_count_o <= count_d;
      tx_valid_o  <= (count_d != '0);
      // When the captured word becomes the new head (the buffer was empty,
      // or its only word pops in the same cycle), forward it directly.
      tx_data_o   <= (push && (wr_ptr_q == rd_ptr_d)) ? data_b_i : mem_q[rd_ptr_d];
    end
  end

endmodule
